cla_nibble_serial_adder: RTL and testbench
==========================================

// Module: cla_nibble_serial_adder
// PURPOSE
// - Clocked WIDTH-bit adder that reuses one cla4 slice over WIDTH/4 cycles, least-significant nibble first.
// - Sits directly around cla4. Each cycle it feeds cla4 one nibble pair plus the stored carry.
// - It collects cla4's s/co into a result register.
// - Trades latency for area. Drives the datapath with a start/busy/done handshake.
// PARAMETERS
// - WIDTH  32  operand/sum width in bits; must be a multiple of 4 and >= 8
// PORTS
// - clk    in   1      rising-edge clock
// - reset  in   1      asynchronous, active-high reset
// - start  in   1      request; sampled only when accept condition holds
// - a      in   WIDTH  operand A, captured on accepted start
// - b      in   WIDTH  operand B, captured on accepted start
// - ci     in   1      carry-in, captured on accepted start
// - busy   out  1      high while state==RUN
// - done   out  1      one-cycle pulse: s/co valid and newly updated
// - s      out  WIDTH  registered sum, held until the next completion
// - co     out  1      registered carry-out, held until the next completion
// BEHAVIOUR
// - Reset (async, active-high): state=IDLE; busy=0, done=0, s=0, co=0.
// - Reset also clears idx, the carry flop and the operand/partial registers.
// - States: IDLE, RUN, DONE.
// - Accept condition: start=1 in IDLE or DONE (back-to-back allowed).
// - On the accepting edge: latch a, b, ci; idx<=0; state<=RUN.
// - RUN, each edge:
//   - cla4 gets a_reg[4*idx+:4], b_reg[4*idx+:4] and the carry flop.
//   - Its s goes to part[4*idx+:4]; its co goes to the carry flop; idx++.
// - RUN exit: on the edge that processes nibble WIDTH/4-1:
//   - s<=full sum including that nibble; co<=that nibble's co.
//   - state<=DONE.
// - DONE: done=1 for exactly one cycle. Next edge goes to RUN if start=1, else IDLE.
// - Latency: done is high in the cycle after WIDTH/4 RUN edges.
//   - That is WIDTH/4 clocks after the accepting edge (8 for WIDTH=32).
// - start during RUN is ignored. a/b/ci changes during RUN have no effect.
// - Arithmetic: {co,s} = a + b + ci, unsigned and modulo 2^(WIDTH+1). Wrap-around shows only via co.
// - s/co change only on the completion edge. They never show partial sums.
// - Reset mid-RUN aborts the operation: s/co return to 0 and no done pulse is produced.
// CONFIGURATION
// - Macro CLA_SERIAL_OVF_EN:
//   - Defined: adds port ovf (out, 1), registered with s/co and reset to 0.
//   - ovf = signed overflow = carry into MSB ^ co of the last nibble.
//   - Not defined: no ovf port and no extra logic.
// STRUCTURE
// - Shared include cla_defs.vh holds the state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
// - It also holds NIBBLE=4.
// - Sub-module: the existing cla4 (s, co, a, b, ci), instantiated once.
// - No other sub-modules. idx counter width is $clog2(WIDTH/4).
// TESTING
// - Reset, then idle: s=0, co=0, busy=0, done=0 for 10 cycles with start=0.
// - a=32'h0000_0004, b=32'h0000_0008, ci=0, start 1 cycle:
//   - busy for 8 cycles, then done 1 cycle.
//   - s=32'h0000_000C, co=0.
// - a=32'hFFFF_FFFF, b=32'h0000_0001, ci=0 (full carry ripple):
//   - s=32'h0000_0000, co=1.
//   - With CLA_SERIAL_OVF_EN: ovf=0.
// - a=32'h7FFF_FFFF, b=32'h0000_0001, ci=1:
//   - s=32'h8000_0001, co=0; ovf=1 when enabled.
//   - Start held during RUN is ignored (one done only).
// - Back-to-back: a second start in the DONE cycle with a=32'h0000_000F, b=32'h0000_000E, ci=0:
//   - second done exactly 9 cycles after the first.
//   - s=32'h0000_001D.
// - Reset asserted at the 4th RUN cycle:
//   - s=0, co=0, busy=0 immediately (async), no done pulse.
//   - A new operation after release completes correctly.

Source files
------------

// File: rtl/cla_nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial CLA adder: slice width and FSM encoding.
package cla_nibble_serial_adder_pkg;

   localparam int unsigned Nibble = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/cla_nibble_serial_adder_cla4.sv
// cla4: 4-bit carry-lookahead adder slice, purely combinational.
module cla4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       ci_i,
   output logic [3:0] s_o,
   output logic       co_o
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   // Generate/propagate terms and flattened lookahead carries
   always_comb begin
      g    = a_i & b_i;
      p    = a_i ^ b_i;
      c[0] = ci_i;
      c[1] = g[0] | (p[0] & ci_i);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci_i);
      co_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci_i);
      s_o  = p ^ c;
   end

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: Width-bit adder built from one cla4 slice used over Width/4 cycles,
// least-significant nibble first, with a start/busy/done handshake.
// Optional feature: define CLA_SERIAL_OVF_EN to add a registered signed-overflow output ovf_o.
module cla_nibble_serial_adder
   import cla_nibble_serial_adder_pkg::*;
#(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   input  logic             ci_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [Width-1:0] s_o,
   output logic             co_o
`ifdef CLA_SERIAL_OVF_EN
   ,
   output logic             ovf_o
`endif
);

   localparam int unsigned NumNib = Width / Nibble;
   localparam int unsigned IdxW   = $clog2(NumNib);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumNib - 1);

   state_e            state_q, state_d;
   logic [IdxW-1:0]   idx_q;
   logic [Width-1:0]  a_q, b_q;
   logic              carry_q;
   logic [Width-1:0]  part_q, part_d;
   logic [Width-1:0]  s_q;
   logic              co_q;

   logic              accept;
   logic              last;
   logic [Nibble-1:0] nib_a, nib_b, nib_s;
   logic              nib_co;

   // Handshake decode: a new request is taken whenever the engine is not mid-run
   always_comb begin
      accept = start_i && ((state_q == StIdle) || (state_q == StDone));
      last   = (state_q == StRun) && (idx_q == LastIdx);
      nib_a  = a_q[Nibble*idx_q +: Nibble];
      nib_b  = b_q[Nibble*idx_q +: Nibble];
   end

   cla4 u_cla4 (
      .a_i  (nib_a),
      .b_i  (nib_b),
      .ci_i (carry_q),
      .s_o  (nib_s),
      .co_o (nib_co)
   );

   // Merge the current slice result into the partial sum
   always_comb begin
      part_d = part_q;
      part_d[Nibble*idx_q +: Nibble] = nib_s;
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StRun;
         StRun:   if (last) state_d = StDone;
         StDone:  state_d = start_i ? StRun : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy_o = (state_q == StRun);
      done_o = (state_q == StDone);
   end

   // Datapath: operand capture, per-nibble accumulation, result update on completion only
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         part_q  <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
      end else begin
         if (accept) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= ci_i;
            idx_q   <= '0;
            part_q  <= '0;
         end else if (state_q == StRun) begin
            part_q  <= part_d;
            carry_q <= nib_co;
            idx_q   <= idx_q + IdxW'(1);
         end
         if (last) begin
            s_q  <= part_d;
            co_q <= nib_co;
         end
      end
   end

`ifdef CLA_SERIAL_OVF_EN
   logic ovf_q;

   // Signed overflow: carry into the MSB (recovered from the top slice) xor carry out of it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_q <= 1'b0;
      end else if (last) begin
         ovf_q <= nib_a[Nibble-1] ^ nib_b[Nibble-1] ^ nib_s[Nibble-1] ^ nib_co;
      end
   end

   assign ovf_o = ovf_q;
`endif

   assign s_o  = s_q;
   assign co_o = co_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Scoreboard bench for cla_nibble_serial_adder (Width=32): stimulus pushes expected results
// computed with plain arithmetic; a monitor pops and compares on every done pulse.
module tb_cla_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [31:0] a_i, b_i;
   logic        ci_i;
   logic        busy_o, done_o;
   logic [31:0] s_o;
   logic        co_o;
`ifdef CLA_SERIAL_OVF_EN
   logic        ovf_o;
`endif

   always #5 clk = ~clk;

   cla_nibble_serial_adder #(.Width(32)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .ci_i    (ci_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .s_o     (s_o),
      .co_o    (co_o)
`ifdef CLA_SERIAL_OVF_EN
      ,
      .ovf_o   (ovf_o)
`endif
   );

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        ovf;
   } exp_t;

   exp_t sb_q[$];
   int   sb_err = 0, sb_chk = 0, done_cnt = 0;
   int   dir_err = 0, dir_chk = 0;

   function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic ci);
      exp_t        e;
      logic [32:0] sum;
      sum   = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      e.s   = sum[31:0];
      e.co  = sum[32];
      e.ovf = (a[31] == b[31]) && (e.s[31] != a[31]);
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && done_o) begin
            done_cnt++;
            sb_chk++;
            if (sb_q.size() == 0) begin
               sb_err++;
               $display("FAIL unexpected_done: done pulse with no operation outstanding, s=%h", s_o);
            end else begin
               e = sb_q.pop_front();
               if (s_o !== e.s || co_o !== e.co) begin
                  sb_err++;
                  $display("FAIL result: got co=%b s=%h, expected co=%b s=%h", co_o, s_o, e.co, e.s);
               end
`ifdef CLA_SERIAL_OVF_EN
               sb_chk++;
               if (ovf_o !== e.ovf) begin
                  sb_err++;
                  $display("FAIL ovf: got %b, expected %b (s=%h)", ovf_o, e.ovf, e.s);
               end
`endif
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      dir_chk++;
      if (act !== exp) begin
         dir_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge: present operands and raise start
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input bit push);
      a_i     = a;
      b_i     = b;
      ci_i    = ci;
      start_i = 1'b1;
      if (push) sb_q.push_back(model(a, b, ci));
   endtask

   // Count negedges until done (inclusive) and busy cycles seen on the way, bounded
   task automatic wait_done(output int n, output int busy_n);
      n      = 0;
      busy_n = 0;
      do begin
         @(negedge clk);
         n++;
         if (busy_o) busy_n++;
      end while (!done_o && n < 40);
      chk("done_within_budget", {63'd0, done_o}, 64'd1);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input string tag);
      int n, bn;
      issue(a, b, ci, 1'b1);
      @(posedge clk);
      #1 start_i = 1'b0;
      wait_done(n, bn);
      chk({tag, "_latency"}, 64'(n), 64'd9);
      chk({tag, "_busy_cycles"}, 64'(bn), 64'd8);
   endtask

   initial begin
      int n, bn, d0;
      rst     = 1'b1;
      start_i = 1'b0;
      a_i     = '0;
      b_i     = '0;
      ci_i    = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state", {s_o, 29'd0, co_o, busy_o, done_o}, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_state", {s_o, 29'd0, co_o, busy_o, done_o}, 64'd0);
      end

      run_op(32'h0000_0004, 32'h0000_0008, 1'b0, "small");
      @(negedge clk);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "ripple");
      @(negedge clk);

      // Start held through most of RUN must not spawn a second operation
      d0 = done_cnt;
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
      @(posedge clk);
      repeat (6) @(negedge clk);
      start_i = 1'b0;
      wait_done(n, bn);
      repeat (12) @(negedge clk);
      chk("held_start_single_done", 64'(done_cnt - d0), 64'd1);
      chk("held_start_idle_after", {63'd0, busy_o}, 64'd0);

      // Back-to-back: second start presented during the DONE cycle
      issue(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b1);
      @(posedge clk);
      #1 start_i = 1'b0;
      wait_done(n, bn);
      issue(32'h0000_000F, 32'h0000_000E, 1'b0, 1'b1);
      @(posedge clk);
      #1 start_i = 1'b0;
      wait_done(n, bn);
      chk("b2b_done_spacing", 64'(n), 64'd9);
      @(negedge clk);

      // Reset in the 4th RUN cycle aborts: outputs clear at once and no done follows
      d0 = done_cnt;
      issue(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0);
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_outputs", {s_o, 29'd0, co_o, busy_o, done_o}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      run_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, "after_abort");

      // Randomized operations with occasional idle gaps
      for (int i = 0; i < 16; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = (i % 4 == 0) ? ~ra : $urandom;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         run_op(ra, rb, 1'($urandom_range(0, 1)), "random");
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", dir_err + sb_err, dir_chk + sb_chk);
      $finish;
   end

endmodule
